buffer: RTL and testbench

- Single-clock synchronous FIFO used as the DMA engine's staging buffer between the source-read and destination-write phases.
- One shared request strobe with a direction bit: each accepted cycle is either a write (push) or a read (pop), never both.
- Read data is registered and returned with a one-cycle valid pulse.

---
 rtl/buffer.sv | 51 +++++
 tb/tb_buffer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/buffer.sv
// buffer: single-clock FIFO staging words between DMA source-read and destination-write phases
module buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rd0_wr1,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid
);
    localparam int AW = $clog2(DEPTH) < 1 ? 1 : $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
    logic [CW-1:0] count;
    logic empty, full, do_wr, do_rd;
    // request decode and explicit-compare pointer wrap so any DEPTH works
    always_comb begin
        empty  = count == '0;
        full   = count == CW'(DEPTH);
        do_wr  = i_valid && i_rd0_wr1 && !full;
        do_rd  = i_valid && !i_rd0_wr1 && !empty;
        wr_nxt = wr_ptr == AW'(DEPTH - 1) ? '0 : wr_ptr + AW'(1);
        rd_nxt = rd_ptr == AW'(DEPTH - 1) ? '0 : rd_ptr + AW'(1);
    end
    // storage array; contents are not cleared on reset
    always_ff @(posedge clk) begin
        if (do_wr && !rst) mem[wr_ptr] <= i_data;
    end
    // pointers, occupancy and registered read port with one-cycle valid pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
        end else begin
            o_valid <= do_rd;
            if (do_wr) wr_ptr <= wr_nxt;
            if (do_rd) begin
                rd_ptr <= rd_nxt;
                o_data <= mem[rd_ptr];
            end
            count <= do_wr ? count + CW'(1) : do_rd ? count - CW'(1) : count;
        end
    end
endmodule

// File: tb/tb_buffer.sv
// tb_buffer: directed self-checking bench for the buffer FIFO
module tb_buffer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_rd0_wr1 = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_data = '0;
    logic [31:0] o_data;
    logic        o_valid;
    int checks = 0;
    int failures = 0;

    buffer #(.DATA_WIDTH(32), .DEPTH(16)) dut (
        .clk(clk), .rst(rst), .i_rd0_wr1(i_rd0_wr1), .i_valid(i_valid),
        .i_data(i_data), .o_data(o_data), .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    task automatic push(input logic [31:0] d);
        @(negedge clk);
        i_valid = 1'b1; i_rd0_wr1 = 1'b1; i_data = d;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic pop();
        @(negedge clk);
        i_valid = 1'b1; i_rd0_wr1 = 1'b0;
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        i_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 32'h0) begin
            failures++;
            $display("FAIL reset: o_valid=%b o_data=%h want 0/00000000", o_valid, o_data);
        end
        idle();
        checks++;
        if (o_valid !== 1'b0 || o_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_idle: o_valid=%b o_data=%h want 0/00000000", o_valid, o_data);
        end
        pop();
        checks++;
        if (o_valid !== 1'b0 || o_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_empty_read: o_valid=%b o_data=%h want 0/00000000", o_valid, o_data);
        end
    endtask

    task automatic test_in_order();
        logic [31:0] v [8] = '{32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD,
                               32'hEEEEEEEE, 32'h0FFFFFFF, 32'hAAAAAAAA, 32'h00000CCC};
        for (int i = 0; i < 8; i++) push(v[i]);
        for (int i = 0; i < 8; i++) begin
            pop();
            checks++;
            if (o_valid !== 1'b1 || o_data !== v[i]) begin
                failures++;
                $display("FAIL in_order[%0d]: o_valid=%b o_data=%h want 1/%h", i, o_valid, o_data, v[i]);
            end
        end
        idle();
        checks++;
        if (o_valid !== 1'b0) begin
            failures++;
            $display("FAIL in_order_pulse: o_valid=%b want 0", o_valid);
        end
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) push(32'(i));
        push(32'hDEADBEEF);
        for (int i = 0; i < 16; i++) begin
            pop();
            checks++;
            if (o_valid !== 1'b1 || o_data !== 32'(i)) begin
                failures++;
                $display("FAIL full[%0d]: o_valid=%b o_data=%h want 1/%h", i, o_valid, o_data, 32'(i));
            end
        end
        pop();
        checks++;
        if (o_valid !== 1'b0 || o_data !== 32'h0000000F) begin
            failures++;
            $display("FAIL full_drop: o_valid=%b o_data=%h want 0/0000000f", o_valid, o_data);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) push(32'h200 + 32'(i));
        for (int i = 0; i < 10; i++) begin
            pop();
            checks++;
            if (o_valid !== 1'b1 || o_data !== 32'h200 + 32'(i)) begin
                failures++;
                $display("FAIL wrap_pre[%0d]: o_valid=%b o_data=%h want 1/%h", i, o_valid, o_data, 32'h200 + 32'(i));
            end
        end
        for (int i = 0; i < 12; i++) push(32'h100 + 32'(i));
        for (int i = 0; i < 12; i++) begin
            pop();
            checks++;
            if (o_valid !== 1'b1 || o_data !== 32'h100 + 32'(i)) begin
                failures++;
                $display("FAIL wrap[%0d]: o_valid=%b o_data=%h want 1/%h", i, o_valid, o_data, 32'h100 + 32'(i));
            end
        end
    endtask

    task automatic test_empty_hold();
        pop();
        checks++;
        if (o_valid !== 1'b0 || o_data !== 32'h10B) begin
            failures++;
            $display("FAIL empty_read: o_valid=%b o_data=%h want 0/0000010b", o_valid, o_data);
        end
        for (int i = 0; i < 3; i++) begin
            idle();
            checks++;
            if (o_valid !== 1'b0 || o_data !== 32'h10B) begin
                failures++;
                $display("FAIL idle_hold[%0d]: o_valid=%b o_data=%h want 0/0000010b", i, o_valid, o_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push(32'h300 + 32'(i));
        @(negedge clk);
        rst = 1'b1; i_valid = 1'b1; i_rd0_wr1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; i_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid: o_valid=%b o_data=%h want 0/00000000", o_valid, o_data);
        end
        pop();
        checks++;
        if (o_valid !== 1'b0 || o_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_mid_empty: o_valid=%b o_data=%h want 0/00000000", o_valid, o_data);
        end
        push(32'h55AA55AA);
        pop();
        checks++;
        if (o_valid !== 1'b1 || o_data !== 32'h55AA55AA) begin
            failures++;
            $display("FAIL reset_mid_reuse: o_valid=%b o_data=%h want 1/55aa55aa", o_valid, o_data);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_full();
        test_wrap();
        test_empty_hold();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
